// File: rtl/x86_inst_decoder.sv
// rtl/x86_inst_decoder.sv - x86-64 instruction-length decoder with registered ASCII trace
// Ports: clk; reset (async, active-low); can_decode (window holds 15 valid bytes);
//   decode_bytes (15-byte window, byte 0 in the top byte); bytes_decoded (combinational length);
//   opcode_stream / mnemonic_stream / out_valid (registered ASCII trace of the decoded instruction).
module x86_inst_decoder #(
  parameter int MAX_HEX_BYTES = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        can_decode,
  input  logic [119:0]                decode_bytes,
  output logic [3:0]                  bytes_decoded,
  output logic [24*MAX_HEX_BYTES-1:0] opcode_stream,
  output logic [255:0]                mnemonic_stream,
  output logic                        out_valid
);

  localparam logic [2:0] IMM_NONE = 3'd0, IMM_B = 3'd1, IMM_W = 3'd2,
                         IMM_Z = 3'd3, IMM_V = 3'd4, IMM_GRP3 = 3'd5;
  localparam logic [63:0] BAD_MN = "(bad)";

  // Mnemonics are held right-aligned (as string literals widen) and left-justified on output.
  typedef struct packed {
    logic [63:0] mn;
    logic        modrm;
    logic [2:0]  imm;
  } entry_t;

  function automatic entry_t mk(input logic [63:0] mn, input logic modrm, input logic [2:0] imm);
    return {mn, modrm, imm};
  endfunction

  function automatic logic [63:0] ljust(input logic [63:0] s);
    logic [63:0] r;
    r = s;
    for (int i = 0; i < 8; i++)
      if (r[63:56] == 8'h00) r = {r[55:0], 8'h20};
    return r;
  endfunction

  function automatic logic [63:0] alu_name(input logic [2:0] r);
    case (r)
      3'd0: return "add";
      3'd1: return "or";
      3'd2: return "adc";
      3'd3: return "sbb";
      3'd4: return "and";
      3'd5: return "sub";
      3'd6: return "xor";
      default: return "cmp";
    endcase
  endfunction

  function automatic logic [63:0] grp3_name(input logic [2:0] r);
    case (r)
      3'd0, 3'd1: return "test";
      3'd2: return "not";
      3'd3: return "neg";
      3'd4: return "mul";
      3'd5: return "imul";
      3'd6: return "div";
      default: return "idiv";
    endcase
  endfunction

  function automatic logic [63:0] jcc_name(input logic [3:0] c);
    case (c)
      4'h0: return "jo";   4'h1: return "jno";  4'h2: return "jb";   4'h3: return "jae";
      4'h4: return "je";   4'h5: return "jne";  4'h6: return "jbe";  4'h7: return "ja";
      4'h8: return "js";   4'h9: return "jns";  4'hA: return "jp";   4'hB: return "jnp";
      4'hC: return "jl";   4'hD: return "jge";  4'hE: return "jle";  default: return "jg";
    endcase
  endfunction

  function automatic entry_t map1(input logic [7:0] op);
    entry_t e;
    e = mk(BAD_MN, 1'b0, IMM_NONE);
    if (op[7:6] == 2'b00 && op[2:0] <= 3'd5)
      e = mk(alu_name(op[5:3]), op[2:0] <= 3'd3,
             (op[2:0] == 3'd4) ? IMM_B : (op[2:0] == 3'd5) ? IMM_Z : IMM_NONE);
    else if (op[7:4] == 4'h5) e = mk(op[3] ? "pop" : "push", 1'b0, IMM_NONE);
    else if (op[7:4] == 4'h7) e = mk(jcc_name(op[3:0]), 1'b0, IMM_B);
    else if (op[7:3] == 5'b10110) e = mk("mov", 1'b0, IMM_B);
    else if (op[7:3] == 5'b10111) e = mk("mov", 1'b0, IMM_V);
    else begin
      case (op)
        8'h80, 8'h83:               e = mk("grp1", 1'b1, IMM_B);
        8'h81:                      e = mk("grp1", 1'b1, IMM_Z);
        8'h84, 8'h85:               e = mk("test", 1'b1, IMM_NONE);
        8'h86, 8'h87:               e = mk("xchg", 1'b1, IMM_NONE);
        8'h88, 8'h89, 8'h8A, 8'h8B: e = mk("mov", 1'b1, IMM_NONE);
        8'h8D:                      e = mk("lea", 1'b1, IMM_NONE);
        8'h90:                      e = mk("nop", 1'b0, IMM_NONE);
        8'hC3:                      e = mk("ret", 1'b0, IMM_NONE);
        8'hC7:                      e = mk("mov", 1'b1, IMM_Z);
        8'hCC:                      e = mk("int3", 1'b0, IMM_NONE);
        8'hE8:                      e = mk("call", 1'b0, IMM_Z);
        8'hE9:                      e = mk("jmp", 1'b0, IMM_Z);
        8'hEB:                      e = mk("jmp", 1'b0, IMM_B);
        8'hF4:                      e = mk("hlt", 1'b0, IMM_NONE);
        8'hF6, 8'hF7:               e = mk("grp3", 1'b1, IMM_GRP3);
        8'hFF:                      e = mk("grp5", 1'b1, IMM_NONE);
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic entry_t map0f(input logic [7:0] op);
    entry_t e;
    e = mk(BAD_MN, 1'b0, IMM_NONE);
    if (op[7:4] == 4'h8) e = mk(jcc_name(op[3:0]), 1'b0, IMM_Z);
    else begin
      case (op)
        8'h05:        e = mk("syscall", 1'b0, IMM_NONE);
        8'h1F:        e = mk("nop", 1'b1, IMM_NONE);
        8'hAF:        e = mk("imul", 1'b1, IMM_NONE);
        8'hB6, 8'hB7: e = mk("movzx", 1'b1, IMM_NONE);
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic logic is_prefix(input logic [7:0] x);
    case (x)
      8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
  endfunction

  logic [7:0]              b [0:14];
  logic [2:0]              pfx_cnt;
  logic                    has_66, scanning, rex_present, rex_w, two_byte;
  logic [3:0]              op_idx, modrm_idx, raw_len, len;
  logic [7:0]              opc, modrm;
  logic [2:0]              sib_base;
  entry_t                  ent;
  logic [4:0]              modrm_len, sib_len, disp_len, imm_len, iz_len, full_len;
  logic [63:0]             mn_sel, mn;
  logic [24*MAX_HEX_BYTES-1:0] ops_next;

  always_comb begin
    for (int k = 0; k < 15; k++) b[k] = decode_bytes[119-8*k -: 8];
  end

  always_comb begin
    pfx_cnt  = 3'd0;
    has_66   = 1'b0;
    scanning = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (scanning && is_prefix(b[i])) begin
        pfx_cnt = pfx_cnt + 3'd1;
        if (b[i] == 8'h66) has_66 = 1'b1;
      end else begin
        scanning = 1'b0;
      end
    end

    rex_present = (b[pfx_cnt][7:4] == 4'h4);
    rex_w       = rex_present & b[pfx_cnt][3];
    op_idx      = {1'b0, pfx_cnt} + {3'b000, rex_present};
    two_byte    = (b[op_idx] == 8'h0F);
    opc         = two_byte ? b[op_idx + 4'd1] : b[op_idx];
    ent         = two_byte ? map0f(opc) : map1(opc);
    modrm_idx   = op_idx + (two_byte ? 4'd2 : 4'd1);
    modrm       = b[modrm_idx];
    sib_base    = b[modrm_idx + 4'd1][2:0];
    raw_len     = modrm_idx;

    modrm_len = 5'd0;
    sib_len   = 5'd0;
    disp_len  = 5'd0;
    imm_len   = 5'd0;
    iz_len    = has_66 ? 5'd2 : 5'd4;

    if (ent.modrm) begin
      modrm_len = 5'd1;
      if (modrm[7:6] != 2'b11 && modrm[2:0] == 3'd4) begin
        sib_len = 5'd1;
        if (modrm[7:6] == 2'b00 && sib_base == 3'd5) disp_len = 5'd4;
      end
      case (modrm[7:6])
        2'b01:   disp_len = 5'd1;
        2'b10:   disp_len = 5'd4;
        2'b00:   if (modrm[2:0] == 3'd5) disp_len = 5'd4;
        default: ;
      endcase
    end

    case (ent.imm)
      IMM_B:    imm_len = 5'd1;
      IMM_W:    imm_len = 5'd2;
      IMM_Z:    imm_len = iz_len;
      IMM_V:    imm_len = rex_w ? 5'd8 : iz_len;
      // Only test (reg 0/1) in the F6/F7 group carries an immediate.
      IMM_GRP3: if (modrm[5:4] == 2'b00) imm_len = opc[0] ? iz_len : 5'd1;
      default:  ;
    endcase

    if (!two_byte && (opc == 8'h80 || opc == 8'h81 || opc == 8'h83)) mn_sel = alu_name(modrm[5:3]);
    else if (ent.imm == IMM_GRP3) mn_sel = grp3_name(modrm[5:3]);
    else mn_sel = ent.mn;

    full_len = {1'b0, raw_len} + modrm_len + sib_len + disp_len + imm_len;

    // A bad opcode consumes its prefixes and opcode bytes; an over-long
    // instruction resyncs by skipping a single byte.
    if (ent.mn == BAD_MN) begin
      len = raw_len;
      mn  = BAD_MN;
    end else if (full_len > 5'd15) begin
      len = 4'd1;
      mn  = BAD_MN;
    end else begin
      len = full_len[3:0];
      mn  = mn_sel;
    end

    for (int i = 0; i < MAX_HEX_BYTES; i++) begin
      if (i < int'(len))
        ops_next[24*(MAX_HEX_BYTES-i)-1 -: 24] = {hex_char(b[i][7:4]), hex_char(b[i][3:0]), 8'h20};
      else
        ops_next[24*(MAX_HEX_BYTES-i)-1 -: 24] = {3{8'h20}};
    end
  end

  assign bytes_decoded = can_decode ? len : 4'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opcode_stream   <= '0;
      mnemonic_stream <= '0;
      out_valid       <= 1'b0;
    end else if (can_decode) begin
      opcode_stream   <= ops_next;
      mnemonic_stream <= {ljust(mn), {24{8'h20}}};
      out_valid       <= 1'b1;
    end else begin
      out_valid       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_x86_inst_decoder.sv
// tb/tb_x86_inst_decoder.sv - self-checking bench for x86_inst_decoder
module tb_x86_inst_decoder;

  typedef logic [7:0] win_t [15];
  typedef struct {
    logic [119:0] win;
    bit           cd;
    int           len;
    string        mn;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         can_decode;
  logic [119:0] decode_bytes;
  logic [3:0]   bytes_decoded;
  logic [191:0] opcode_stream;
  logic [255:0] mnemonic_stream;
  logic         out_valid;

  int n_chk = 0;
  int n_fail = 0;
  logic [191:0] last_ops = '0;
  logic [255:0] last_mn = '0;

  always #5 clk = ~clk;

  x86_inst_decoder dut (
    .clk(clk), .reset(reset), .can_decode(can_decode), .decode_bytes(decode_bytes),
    .bytes_decoded(bytes_decoded), .opcode_stream(opcode_stream),
    .mnemonic_stream(mnemonic_stream), .out_valid(out_valid)
  );

  string nm1[256];
  string nm2[256];
  bit    mr1[256];
  bit    mr2[256];
  int    im1[256];
  int    im2[256];
  string alu[8] = '{"add", "or", "adc", "sbb", "and", "sub", "xor", "cmp"};
  string g3[8]  = '{"test", "test", "not", "neg", "mul", "imul", "div", "idiv"};
  string jcc[16] = '{"jo", "jno", "jb", "jae", "je", "jne", "jbe", "ja",
                     "js", "jns", "jp", "jnp", "jl", "jge", "jle", "jg"};
  logic [7:0] pfx_list[11] = '{8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
  logic [7:0] good1[32] = '{8'h00, 8'h01, 8'h03, 8'h05, 8'h0D, 8'h3D, 8'h50, 8'h5F, 8'h74, 8'h7F,
                            8'h80, 8'h81, 8'h83, 8'h85, 8'h87, 8'h89, 8'h8B, 8'h8D, 8'h90, 8'hB0,
                            8'hB8, 8'hBF, 8'hC3, 8'hC7, 8'hCC, 8'hE8, 8'hE9, 8'hEB, 8'hF4, 8'hF6,
                            8'hF7, 8'hFF};
  logic [7:0] good2[9] = '{8'h05, 8'h1F, 8'h80, 8'h85, 8'h8F, 8'hAF, 8'hB6, 8'hB7, 8'h0B};

  // imm codes: 0 none, 1 ib, 2 iw, 3 iz, 4 iv, 5 F6/F7 group rule
  task automatic set1(input int op, input string n, input bit m, input int im);
    nm1[op] = n; mr1[op] = m; im1[op] = im;
  endtask

  task automatic set2(input int op, input string n, input bit m, input int im);
    nm2[op] = n; mr2[op] = m; im2[op] = im;
  endtask

  task automatic init_tables();
    for (int i = 0; i < 256; i++) begin
      set1(i, "(bad)", 1'b0, 0);
      set2(i, "(bad)", 1'b0, 0);
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 6; c++)
        set1(8*r + c, alu[r], c < 4, (c == 4) ? 1 : (c == 5) ? 3 : 0);
    for (int i = 0; i < 8; i++) begin
      set1(8'h50 + i, "push", 1'b0, 0);
      set1(8'h58 + i, "pop", 1'b0, 0);
      set1(8'hB0 + i, "mov", 1'b0, 1);
      set1(8'hB8 + i, "mov", 1'b0, 4);
    end
    for (int i = 0; i < 16; i++) begin
      set1(8'h70 + i, jcc[i], 1'b0, 1);
      set2(8'h80 + i, jcc[i], 1'b0, 3);
    end
    set1(8'h80, "grp1", 1'b1, 1); set1(8'h81, "grp1", 1'b1, 3); set1(8'h83, "grp1", 1'b1, 1);
    set1(8'h84, "test", 1'b1, 0); set1(8'h85, "test", 1'b1, 0);
    set1(8'h86, "xchg", 1'b1, 0); set1(8'h87, "xchg", 1'b1, 0);
    for (int i = 8'h88; i <= 8'h8B; i++) set1(i, "mov", 1'b1, 0);
    set1(8'h8D, "lea", 1'b1, 0);  set1(8'h90, "nop", 1'b0, 0);
    set1(8'hC3, "ret", 1'b0, 0);  set1(8'hC7, "mov", 1'b1, 3);
    set1(8'hCC, "int3", 1'b0, 0); set1(8'hE8, "call", 1'b0, 3);
    set1(8'hE9, "jmp", 1'b0, 3);  set1(8'hEB, "jmp", 1'b0, 1);
    set1(8'hF4, "hlt", 1'b0, 0);  set1(8'hF6, "grp3", 1'b1, 5);
    set1(8'hF7, "grp3", 1'b1, 5); set1(8'hFF, "grp5", 1'b1, 0);
    set2(8'h05, "syscall", 1'b0, 0); set2(8'h1F, "nop", 1'b1, 0);
    set2(8'hAF, "imul", 1'b1, 0);    set2(8'hB6, "movzx", 1'b1, 0);
    set2(8'hB7, "movzx", 1'b1, 0);
  endtask

  function automatic bit is_pfx(input logic [7:0] x);
    foreach (pfx_list[k]) if (pfx_list[k] == x) return 1'b1;
    return 1'b0;
  endfunction

  // Walks the byte window left to right, adding up field sizes.
  function automatic void model(input win_t w, output int len, output string mn);
    int i, op, imm;
    bit o16, rexw, two, mr;
    string n;
    logic [7:0] m;
    i = 0; o16 = 0; rexw = 0;
    while (i < 4 && is_pfx(w[i])) begin
      if (w[i] == 8'h66) o16 = 1;
      i++;
    end
    if (w[i][7:4] == 4'h4) begin rexw = w[i][3]; i++; end
    two = (w[i] == 8'h0F);
    if (two) begin op = int'(w[i+1]); n = nm2[op]; mr = mr2[op]; imm = im2[op]; i += 2; end
    else     begin op = int'(w[i]);   n = nm1[op]; mr = mr1[op]; imm = im1[op]; i += 1; end
    if (n == "(bad)") begin len = i; mn = n; return; end
    m = w[i];
    if (mr) begin
      i++;
      if (m[7:6] != 2'd3 && m[2:0] == 3'd4) begin
        if (m[7:6] == 2'd0 && w[i][2:0] == 3'd5) i += 4;
        i++;
      end
      if (m[7:6] == 2'd1) i += 1;
      else if (m[7:6] == 2'd2) i += 4;
      else if (m[7:6] == 2'd0 && m[2:0] == 3'd5) i += 4;
    end
    if (!two && (op == 8'h80 || op == 8'h81 || op == 8'h83)) n = alu[m[5:3]];
    if (imm == 5) begin
      n = g3[m[5:3]];
      imm = (m[5:3] < 2) ? ((op == 8'hF6) ? 1 : 3) : 0;
    end
    case (imm)
      1: i += 1;
      2: i += 2;
      3: i += o16 ? 2 : 4;
      4: i += rexw ? 8 : (o16 ? 2 : 4);
      default: ;
    endcase
    if (i > 15) begin len = 1; mn = "(bad)"; end
    else begin len = i; mn = n; end
  endfunction

  function automatic logic [119:0] lw(input logic [119:0] v, input int n);
    return v << (8 * (15 - n));
  endfunction

  function automatic win_t unpack(input logic [119:0] v);
    win_t w;
    for (int k = 0; k < 15; k++) w[k] = v[119-8*k -: 8];
    return w;
  endfunction

  function automatic logic [119:0] pack(input win_t w);
    logic [119:0] v;
    for (int k = 0; k < 15; k++) v[119-8*k -: 8] = w[k];
    return v;
  endfunction

  function automatic logic [191:0] fmt_ops(input win_t w, input int len);
    string s;
    logic [191:0] r;
    s = "";
    for (int k = 0; k < 8; k++) begin
      if (k < len) s = {s, $sformatf("%02x ", w[k])};
      else s = {s, "   "};
    end
    for (int c = 0; c < 24; c++) r[191-8*c -: 8] = s[c];
    return r;
  endfunction

  function automatic logic [255:0] fmt_mn(input string n);
    logic [255:0] r;
    for (int c = 0; c < 32; c++) r[255-8*c -: 8] = (c < n.len()) ? n[c] : 8'h20;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_check(input string tag, input logic [119:0] win, input bit cd,
                             input int exp_len, input string exp_mn);
    win_t w;
    w = unpack(win);
    @(negedge clk);
    decode_bytes = win;
    can_decode   = cd;
    #1;
    chk({tag, ".len"}, 256'(bytes_decoded), cd ? 256'(exp_len) : 256'(0));
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 256'(out_valid), 256'(cd));
    if (cd) begin
      last_ops = fmt_ops(w, exp_len);
      last_mn  = fmt_mn(exp_mn);
    end
    chk({tag, ".ops"}, 256'(opcode_stream), 256'(last_ops));
    chk({tag, ".mn"}, mnemonic_stream, last_mn);
  endtask

  function automatic win_t rnd_win();
    win_t w;
    int p, np, sel;
    for (int k = 0; k < 15; k++) w[k] = 8'($urandom);
    p = 0;
    np = $urandom_range(0, 5);
    for (int k = 0; k < np; k++) begin
      w[p] = pfx_list[$urandom_range(0, 10)];
      p++;
    end
    if ($urandom_range(0, 1) == 1) begin
      w[p] = 8'h40 | 8'($urandom_range(0, 15));
      p++;
    end
    sel = $urandom_range(0, 9);
    if (sel < 5) w[p] = good1[$urandom_range(0, 31)];
    else if (sel < 7) begin
      w[p] = 8'h0F;
      if (sel == 5) w[p+1] = good2[$urandom_range(0, 8)];
    end
    return w;
  endfunction

  vec_t vt[$];

  initial begin
    win_t w;
    int   ml;
    string mm;
    bit   cd;

    init_tables();
    reset = 1'b0;
    can_decode = 1'b0;
    decode_bytes = '0;
    #12;
    chk("rst.valid", 256'(out_valid), 256'(0));
    chk("rst.ops", 256'(opcode_stream), 256'(0));
    chk("rst.mn", mnemonic_stream, 256'(0));
    chk("rst.len", 256'(bytes_decoded), 256'(0));
    @(negedge clk);
    reset = 1'b1;

    vt.push_back('{lw(120'h4889E5, 3), 1'b1, 3, "mov"});
    vt.push_back('{lw(120'h488B042500000000, 8), 1'b1, 8, "mov"});
    vt.push_back('{lw(120'h66B83412, 4), 1'b1, 4, "mov"});
    vt.push_back('{lw(120'h48B81122334455667788, 10), 1'b1, 10, "mov"});
    vt.push_back('{lw(120'hB878563412, 5), 1'b1, 5, "mov"});
    vt.push_back('{lw(120'h0F8510203040, 6), 1'b1, 6, "jne"});
    vt.push_back('{lw(120'hF7C078563412, 6), 1'b1, 6, "test"});
    vt.push_back('{lw(120'hF7D0, 2), 1'b1, 2, "not"});
    vt.push_back('{lw(120'h8345F801, 4), 1'b1, 4, "add"});
    vt.push_back('{lw(120'h06, 1), 1'b1, 1, "(bad)"});
    vt.push_back('{lw(120'h6666666666, 5), 1'b1, 5, "(bad)"});
    vt.push_back('{lw(120'h66666666488184241122334456, 13), 1'b1, 14, "add"});
    vt.push_back('{lw(120'hF0F32E48818424112233447856_3412, 15), 1'b1, 15, "add"});
    vt.push_back('{lw(120'hF0F22E3E48818424112233447856_34, 15), 1'b1, 1, "(bad)"});
    vt.push_back('{lw(120'h0F05, 2), 1'b1, 2, "syscall"});
    vt.push_back('{lw(120'h0F1F4000, 4), 1'b1, 4, "nop"});
    vt.push_back('{lw(120'h8B0500000000, 6), 1'b1, 6, "mov"});
    vt.push_back('{lw(120'hE801020304, 5), 1'b1, 5, "call"});
    vt.push_back('{lw(120'hEB10, 2), 1'b1, 2, "jmp"});
    vt.push_back('{lw(120'h7402, 2), 1'b1, 2, "je"});
    vt.push_back('{lw(120'h50, 1), 1'b1, 1, "push"});
    vt.push_back('{lw(120'hFFD0, 2), 1'b1, 2, "grp5"});
    vt.push_back('{lw(120'hF6C011, 3), 1'b1, 3, "test"});
    vt.push_back('{lw(120'h0FB6C0, 3), 1'b1, 3, "movzx"});
    vt.push_back('{lw(120'h0FAFC1, 3), 1'b1, 3, "imul"});
    vt.push_back('{lw(120'h0F0B, 2), 1'b1, 2, "(bad)"});
    vt.push_back('{lw(120'h4889E5, 3), 1'b0, 0, ""});
    vt.push_back('{lw(120'hC3, 1), 1'b1, 1, "ret"});

    foreach (vt[i]) apply_check($sformatf("vec%0d", i), vt[i].win, vt[i].cd, vt[i].len, vt[i].mn);

    // Asynchronous reset in the middle of a stream, then resume.
    apply_check("pre_rst", lw(120'h4889E5, 3), 1'b1, 3, "mov");
    @(negedge clk);
    reset = 1'b0;
    decode_bytes = lw(120'h0F8510203040, 6);
    can_decode = 1'b1;
    #1;
    chk("midrst.valid", 256'(out_valid), 256'(0));
    chk("midrst.ops", 256'(opcode_stream), 256'(0));
    chk("midrst.mn", mnemonic_stream, 256'(0));
    chk("midrst.len", 256'(bytes_decoded), 256'(6));
    @(posedge clk);
    #1;
    chk("inrst.valid", 256'(out_valid), 256'(0));
    chk("inrst.mn", mnemonic_stream, 256'(0));
    reset = 1'b1;
    last_ops = '0;
    last_mn = '0;
    apply_check("post_rst", lw(120'hC3, 1), 1'b1, 1, "ret");

    for (int n = 0; n < 400; n++) begin
      w = rnd_win();
      cd = ($urandom_range(0, 9) != 0);
      model(w, ml, mm);
      apply_check($sformatf("rnd%0d", n), pack(w), cd, ml, mm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
